// File: rtl/aes_key_share_serializer_pkg.sv
// Shared constants and state encoding for the masked-key serializer.
package aes_key_share_serializer_pkg;

  localparam int unsigned KWORDS_128 = 4;
  localparam int unsigned KWORDS_256 = 8;
  localparam int unsigned KEY_WORD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/aes_key_share_serializer_key_word_counter.sv
// Word/share index pair for the key stream; word wraps at KWORDS-1, share ends at d-1.
// last_o flags the final word of the final share so the caller can end the transfer.
module aes_key_share_serializer_key_word_counter
  import aes_key_share_serializer_pkg::*;
#(
  parameter int unsigned d       = 2,
  parameter int unsigned WORD_W  = 3,
  parameter int unsigned SHARE_W = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               adv_i,
  input  logic               mode_256_i,
  output logic [WORD_W-1:0]  word_idx_o,
  output logic [SHARE_W-1:0] share_idx_o,
  output logic               last_o
);

  logic [WORD_W-1:0]  word_q, word_d, word_last;
  logic [SHARE_W-1:0] share_q, share_d;

  assign word_last   = mode_256_i ? WORD_W'(KWORDS_256 - 1) : WORD_W'(KWORDS_128 - 1);
  assign last_o      = (share_q == SHARE_W'(d - 1)) && (word_q == word_last);
  assign word_idx_o  = word_q;
  assign share_idx_o = share_q;

  // Clear wins over advance so a flush in the same cycle as an accept restarts at 0/0.
  always_comb begin
    word_d  = word_q;
    share_d = share_q;
    if (clr_i) begin
      word_d  = '0;
      share_d = '0;
    end else if (adv_i) begin
      if (last_o) begin
        word_d  = '0;
        share_d = '0;
      end else if (word_q == word_last) begin
        word_d  = '0;
        share_d = share_q + 1'b1;
      end else begin
        word_d  = word_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q  <= '0;
      share_q <= '0;
    end else begin
      word_q  <= word_d;
      share_q <= share_d;
    end
  end

endmodule

// File: rtl/aes_key_share_serializer.sv
// Streams a captured d-share masked key to the AES core as 32-bit words, share-major.
// Key register is zeroized at end of transfer, on flush and on reset.
module aes_key_share_serializer
  import aes_key_share_serializer_pkg::*;
#(
  parameter int unsigned d    = 2,
  parameter int unsigned KMAX = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [KMAX*d-1:0]   in_key_shares_i,
  input  logic                in_mode_256_i,
  input  logic                in_mode_inverse_i,
  input  logic                in_flush_i,
  output logic                out_key_valid_o,
  input  logic                out_key_ready_i,
  output logic [KEY_WORD_W-1:0] out_key_data_o,
  output logic                out_key_mode_256_o,
  output logic                out_key_mode_inverse_o,
  output logic                busy_o
);

  localparam int unsigned SLOT_WORDS = KMAX / KEY_WORD_W;
  localparam int unsigned WORD_W     = (SLOT_WORDS > 1) ? $clog2(SLOT_WORDS) : 1;
  localparam int unsigned SHARE_W    = (d > 1) ? $clog2(d) : 1;

  state_e              state_q;
  logic [KMAX*d-1:0]   key_q;
  logic                mode_256_q;
  logic                mode_inv_q;
  logic [WORD_W-1:0]   word_idx;
  logic [SHARE_W-1:0]  share_idx;
  logic                last_word;
  logic                cnt_clr;
  logic                cnt_adv;
  logic [KEY_WORD_W-1:0] sel_word;

  assign cnt_clr = in_flush_i || (state_q == IDLE);
  assign cnt_adv = (state_q == SEND) && out_key_ready_i;

  aes_key_share_serializer_key_word_counter #(
    .d       (d),
    .WORD_W  (WORD_W),
    .SHARE_W (SHARE_W)
  ) u_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (cnt_clr),
    .adv_i       (cnt_adv),
    .mode_256_i  (mode_256_q),
    .word_idx_o  (word_idx),
    .share_idx_o (share_idx),
    .last_o      (last_word)
  );

  always_comb begin
    sel_word = '0;
    for (int s = 0; s < int'(d); s++) begin
      for (int w = 0; w < int'(SLOT_WORDS); w++) begin
        if (share_idx == SHARE_W'(s) && word_idx == WORD_W'(w)) begin
          sel_word = key_q[KMAX*s + KEY_WORD_W*w +: KEY_WORD_W];
        end
      end
    end
  end

  // Flush overrides both capture and advance; a word accepted alongside it counts as delivered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      key_q      <= '0;
      mode_256_q <= 1'b0;
      mode_inv_q <= 1'b0;
    end else if (in_flush_i) begin
      state_q    <= IDLE;
      key_q      <= '0;
      mode_256_q <= 1'b0;
      mode_inv_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            state_q    <= SEND;
            key_q      <= in_key_shares_i;
            mode_256_q <= in_mode_256_i;
            mode_inv_q <= in_mode_inverse_i;
          end
        end
        SEND: begin
          if (out_key_ready_i && last_word) begin
            state_q    <= IDLE;
            key_q      <= '0;
            mode_256_q <= 1'b0;
            mode_inv_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready is gated by the reset pin so it is low for the whole reset assertion.
  assign in_ready_o             = rst_ni && (state_q == IDLE);
  assign out_key_valid_o        = (state_q == SEND);
  assign busy_o                 = (state_q == SEND);
  assign out_key_data_o         = (state_q == SEND) ? sel_word : '0;
  assign out_key_mode_256_o     = mode_256_q;
  assign out_key_mode_inverse_o = mode_inv_q;

endmodule

// File: tb/tb_aes_key_share_serializer.sv
// Directed bench: instance a is d=2/KMAX=256, instance b is d=3/KMAX=256.
module tb_aes_key_share_serializer;

  logic clk;
  logic rst_n;

  logic         a_valid, a_in_ready, a_m256, a_inv, a_flush;
  logic [511:0] a_key;
  logic         a_oval, a_oready, a_om256, a_oinv, a_busy;
  logic [31:0]  a_dat;

  logic         b_valid, b_in_ready, b_m256, b_inv, b_flush;
  logic [767:0] b_key;
  logic         b_oval, b_oready, b_om256, b_oinv, b_busy;
  logic [31:0]  b_dat;

  int checks;
  int errors;
  logic [31:0] a_got [32];
  logic [31:0] ref_seq [32];

  aes_key_share_serializer #(.d(2), .KMAX(256)) a_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(a_valid), .in_ready_o(a_in_ready), .in_key_shares_i(a_key),
    .in_mode_256_i(a_m256), .in_mode_inverse_i(a_inv), .in_flush_i(a_flush),
    .out_key_valid_o(a_oval), .out_key_ready_i(a_oready), .out_key_data_o(a_dat),
    .out_key_mode_256_o(a_om256), .out_key_mode_inverse_o(a_oinv), .busy_o(a_busy)
  );

  aes_key_share_serializer #(.d(3), .KMAX(256)) b_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(b_valid), .in_ready_o(b_in_ready), .in_key_shares_i(b_key),
    .in_mode_256_i(b_m256), .in_mode_inverse_i(b_inv), .in_flush_i(b_flush),
    .out_key_valid_o(b_oval), .out_key_ready_i(b_oready), .out_key_data_o(b_dat),
    .out_key_mode_256_o(b_om256), .out_key_mode_inverse_o(b_oinv), .busy_o(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hands one bundle to instance a and collects accepted words until in_ready returns.
  task automatic a_run(input logic [511:0] key, input logic m256, input logic inv,
                       input bit stall, output int n, output int cyc);
    logic [15:0] lfsr;
    logic [31:0] pd;
    logic        pm, pi, pstall;
    lfsr = 16'hACE1;
    a_key = key; a_m256 = m256; a_inv = inv; a_valid = 1'b1; a_oready = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; a_m256 = ~m256; a_inv = ~inv;
    n = 0; cyc = 1; pstall = 1'b0; pd = '0; pm = 1'b0; pi = 1'b0;
    while (!a_in_ready && cyc < 200) begin
      if (pstall) begin
        checks++;
        if (a_dat !== pd || a_om256 !== pm || a_oinv !== pi) begin
          errors++;
          $display("FAIL stall_hold got %h/%b/%b want %h/%b/%b", a_dat, a_om256, a_oinv, pd, pm, pi);
        end
      end
      if (a_oval) begin
        checks++;
        if (a_om256 !== m256 || a_oinv !== inv) begin
          errors++;
          $display("FAIL mode_out got %b%b want %b%b", a_om256, a_oinv, m256, inv);
        end
      end
      if (a_oval && a_oready && n < 32) begin
        a_got[n] = a_dat;
        n++;
      end
      pstall = a_oval && !a_oready;
      pd = a_dat; pm = a_om256; pi = a_oinv;
      @(posedge clk); #1;
      cyc++;
      if (stall) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        a_oready = lfsr[0];
      end
    end
    a_oready = 1'b1;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL a_run_timeout cycles %0d limit 200", cyc);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (a_in_ready !== 1'b0 || a_oval !== 1'b0 || a_dat !== 32'h0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b dat=%h busy=%b want 0/0/0/0", a_in_ready, a_oval, a_dat, a_busy);
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || a_om256 !== 1'b0 || a_oinv !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b/%b modes=%b%b want 1/1 00", a_in_ready, b_in_ready, a_om256, a_oinv);
    end
  endtask

  task automatic test_key128();
    logic [511:0] k;
    logic [31:0]  exp_w [8];
    int n, cyc;
    exp_w = '{32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c, 32'h0, 32'h0, 32'h0, 32'h0};
    k = '0;
    k[127:0] = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    a_run(k, 1'b0, 1'b0, 1'b0, n, cyc);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL key128_count got %0d want 8", n); end
    checks++;
    if (cyc !== 9) begin errors++; $display("FAIL key128_latency got %0d want 9", cyc); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (a_got[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL key128_word%0d got %h want %h", i, a_got[i], exp_w[i]);
      end
    end
    checks++;
    if (a_oval !== 1'b0 || a_dat !== 32'h0) begin
      errors++;
      $display("FAIL key128_idle_after got vld=%b dat=%h want 0/0", a_oval, a_dat);
    end
  endtask

  task automatic test_key256_d3();
    int n, cyc;
    logic [31:0] exp;
    b_key = '0;
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 8; w++)
        b_key[256*s + 32*w +: 32] = {8'(s), 16'h0, 8'(w)};
    b_valid = 1'b1; b_m256 = 1'b1; b_inv = 1'b1; b_oready = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0; b_m256 = 1'b0; b_inv = 1'b0;
    n = 0; cyc = 1;
    while (!b_in_ready && cyc < 100) begin
      if (b_oval) begin
        exp = {8'(n / 8), 16'h0, 8'(n % 8)};
        checks++;
        if (b_dat !== exp) begin
          errors++;
          $display("FAIL key256_word%0d got %h want %h", n, b_dat, exp);
        end
        checks++;
        if (b_om256 !== 1'b1 || b_oinv !== 1'b1) begin
          errors++;
          $display("FAIL key256_modes got %b%b want 11", b_om256, b_oinv);
        end
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (n !== 24 || cyc !== 25) begin
      errors++;
      $display("FAIL key256_count got words=%0d cycles=%0d want 24/25", n, cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] k;
    logic [31:0]  exp;
    int n, cyc;
    k = '0;
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 8; w++)
        k[256*s + 32*w +: 32] = {4'hA, 4'(s), 16'h5500, 8'(w)};
    a_run(k, 1'b1, 1'b0, 1'b0, n, cyc);
    for (int i = 0; i < 16; i++) ref_seq[i] = a_got[i];
    a_run(k, 1'b1, 1'b0, 1'b1, n, cyc);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL bp_count got %0d want 16", n); end
    checks++;
    if (cyc <= 17) begin errors++; $display("FAIL bp_no_stall got cycles %0d want >17", cyc); end
    for (int i = 0; i < 16; i++) begin
      exp = {4'hA, 4'(i / 8), 16'h5500, 8'(i % 8)};
      checks++;
      if (a_got[i] !== exp || ref_seq[i] !== exp) begin
        errors++;
        $display("FAIL bp_word%0d got %h nostall %h want %h", i, a_got[i], ref_seq[i], exp);
      end
    end
  endtask

  task automatic test_flush();
    logic [511:0] k;
    int n, cyc;
    k = '0;
    k[127:0]   = 128'h44444444_33333333_22222222_11111111;
    k[383:256] = 128'h88888888_77777777_66666666_55555555;
    a_key = k; a_m256 = 1'b0; a_inv = 1'b1; a_valid = 1'b1; a_oready = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (a_dat !== 32'h44444444 || a_oval !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre got vld=%b dat=%h want 1/44444444", a_oval, a_dat);
    end
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    checks++;
    if (a_oval !== 1'b0 || a_dat !== 32'h0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle got vld=%b dat=%h rdy=%b busy=%b want 0/0/1/0", a_oval, a_dat, a_in_ready, a_busy);
    end
    checks++;
    if (a_dut.key_q !== 512'h0 || a_oinv !== 1'b0) begin
      errors++;
      $display("FAIL flush_zeroize got key_nonzero=%b inv=%b want 0/0", |a_dut.key_q, a_oinv);
    end
    k[127:0] = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;
    a_run(k, 1'b0, 1'b0, 1'b0, n, cyc);
    checks++;
    if (n !== 8 || a_got[0] !== 32'haaaaaaaa || a_got[4] !== 32'h55555555) begin
      errors++;
      $display("FAIL flush_restart got n=%0d w0=%h w4=%h want 8/aaaaaaaa/55555555", n, a_got[0], a_got[4]);
    end
  endtask

  task automatic test_valid_flush_idle();
    a_key = {16{32'hdeadbeef}}; a_m256 = 1'b1; a_valid = 1'b1; a_flush = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; a_flush = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_oval !== 1'b0 || a_in_ready !== 1'b1 || a_dut.key_q !== 512'h0) begin
      errors++;
      $display("FAIL valid_flush got busy=%b vld=%b rdy=%b key_nonzero=%b want 0/0/1/0",
               a_busy, a_oval, a_in_ready, |a_dut.key_q);
    end
  endtask

  task automatic test_async_reset();
    a_key = {16{32'h5a5a5a5a}}; a_m256 = 1'b1; a_inv = 1'b0; a_valid = 1'b1; a_oready = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (a_oval !== 1'b1) begin errors++; $display("FAIL arst_pre got vld=%b want 1", a_oval); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_oval !== 1'b0 || a_dat !== 32'h0 || a_in_ready !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate got vld=%b dat=%h rdy=%b busy=%b want 0/0/0/0", a_oval, a_dat, a_in_ready, a_busy);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1) begin errors++; $display("FAIL arst_release got rdy=%b want 1", a_in_ready); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (a_oval !== 1'b0 || a_dat !== 32'h0) begin
        errors++;
        $display("FAIL arst_residual cycle %0d got vld=%b dat=%h want 0/0", i, a_oval, a_dat);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    a_valid = 1'b0; a_key = '0; a_m256 = 1'b0; a_inv = 1'b0; a_flush = 1'b0; a_oready = 1'b1;
    b_valid = 1'b0; b_key = '0; b_m256 = 1'b0; b_inv = 1'b0; b_flush = 1'b0; b_oready = 1'b1;
    test_reset();
    test_key128();
    test_key256_d3();
    test_backpressure();
    test_flush();
    test_valid_flush_idle();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_share_serializer.md
Name: aes_key_share_serializer

Overview:
- Transmitter side of the AES core's 32-bit key-loading interface.
- Accepts one complete masked key (all d shares, 128- or 256-bit) with its mode flags in a single handshake.
- Streams the key to the core's key input as 32-bit words over a valid/ready interface, in the order the core expects:
  - share 0, word 0 to KWORDS-1;
  - then share 1, and so on up to share d-1.
- Zeroizes its key register when the transfer finishes or is flushed.

Parameters:
- d, 2, number of shares (d >= 2).
- KMAX, 256, width of one share slot in bits; key sizes 128 and 256 are supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  key bundle valid.
- in_ready  out  1  serializer can accept a bundle.
- in_key_shares  in  KMAX*d  share i at bits [KMAX*i +: KMAX]; for 128-bit keys only the low 128 bits of each slot are used.
- in_mode_256  in  1  1 = 256-bit key (KWORDS=8), 0 = 128-bit key (KWORDS=4).
- in_mode_inverse  in  1  decryption-key flag, forwarded unchanged.
- in_flush  in  1  synchronous abort and zeroize.
- out_key_valid  out  1  word valid toward the core.
- out_key_ready  in  1  core accepts the word.
- out_key_data  out  32  current key word.
- out_key_mode_256  out  1  registered mode, stable for the whole transfer.
- out_key_mode_inverse  out  1  registered inverse flag, stable for the whole transfer.
- busy  out  1  high in SEND.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, key register=0, share_cnt=0, word_cnt=0, mode registers=0.
  - out_key_valid=0, out_key_data=0, busy=0, in_ready=0 while rst is asserted.
- State IDLE:
  - in_ready=1, out_key_valid=0, out_key_data=0.
  - If in_valid=1 and in_flush=0: capture in_key_shares, in_mode_256 and in_mode_inverse; clear both counters; next state=SEND.
  - First word is valid in the cycle after capture (one-cycle capture latency).
- State SEND:
  - in_ready=0, out_key_valid=1, busy=1.
  - out_key_data = key_reg[KMAX*share_cnt + 32*word_cnt +: 32].
  - Data and mode outputs are held stable while out_key_ready=0. No word is dropped or repeated.
- Advance on out_key_valid & out_key_ready:
  - word_cnt increments; at word_cnt=KWORDS-1 it wraps to 0 and share_cnt increments.
  - On the last word (share_cnt=d-1, word_cnt=KWORDS-1): key register, counters and mode registers clear to 0; next state=IDLE.
- Timing: total transfer is d*KWORDS words. With out_key_ready held at 1, one bundle occupies d*KWORDS+1 cycles from input handshake to in_ready re-asserting. There is no bypass of the IDLE cycle.
- in_flush=1 in any state: next cycle is IDLE, with key register, counters and mode registers zeroed.
  - Flush has priority over capture: in IDLE, in_valid is ignored.
  - Flush has priority over advance in SEND. If the core accepted a word in the same cycle, that word is considered delivered but the transfer is abandoned.
- Mode is sampled only at capture; changes on in_mode_* during SEND have no effect.
- Key material never appears on out_key_data outside SEND.

Decomposition:
- Shared include/package holds:
  - KWORDS_128=4, KWORDS_256=8;
  - key word width 32;
  - state encoding IDLE=1'b0, SEND=1'b1.
- The word-index counter pair (word_cnt with wrap at KWORDS-1, share_cnt with terminal at d-1) is a natural sub-module: key_word_counter. Its outputs are index and last.
- Word selection is a flat mux, or optionally a right-shift of a packed register. Both are acceptable if the output sequence is identical.

Test Plan:
- 128-bit key, d=2, share0=128'h0f0e0d0c_0b0a0908_07060504_03020100, share1=0, out_key_ready=1:
  - Required words: 0x03020100, 0x07060504, 0x0b0a0908, 0x0f0e0d0c, then 4x 0x00000000.
  - in_ready high again 9 cycles after the input handshake; mode_256=0 throughout.
- 256-bit key, d=3, in_mode_inverse=1, each share's words k = {share, k} as 32'hSS0000KK:
  - Required: exactly 24 words in share-major, word-minor order; out_key_mode_256=1 and out_key_mode_inverse=1 on every word.
- Random back-pressure (out_key_ready from an LFSR):
  - Required: out_key_data and both mode outputs unchanged on every valid&!ready cycle; sequence identical to the no-stall case.
- Flush after 3 accepted words of a 128-bit, d=2 transfer:
  - Required: next cycle state IDLE, out_key_valid=0, out_key_data=0, key register all-zero.
  - A following bundle starts again at share0/word0.
- in_valid and in_flush both high in IDLE:
  - Required: no capture, stays IDLE.
- Async reset asserted mid-SEND:
  - Required: out_key_valid drops without waiting for a clock edge; after release in_ready=1 and no residual key word is emitted.
